// File: rtl/dex_pkg.sv
// Shared types and constants for the decode/execute pipeline stage controller.
package dex_pkg;

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      VPU    = 2'd1,
      WAIT   = 2'd2
   } kind_e;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      VPU_LAUNCH = 2'd1,
      VPU_WAIT   = 2'd2,
      TIMED_WAIT = 2'd3
   } state_e;

   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

   // Encoding 3 is reserved and executes as an ordinary instruction.
   function automatic kind_e decode_kind(input logic [1:0] raw);
      case (raw)
         2'd1:    return VPU;
         2'd2:    return WAIT;
         default: return NORMAL;
      endcase
   endfunction

endpackage

// File: rtl/dex_fwd_mux.sv
// Priority bypass mux: the lowest-numbered writeback port that hits the source wins.
module dex_fwd_mux #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5,
   parameter int NUM_WB = 2
) (
   input  logic [ADDR_W-1:0]        src_addr,
   input  logic [DATA_W-1:0]        rf_data,
   input  logic [NUM_WB-1:0]        wb_we,
   input  logic [NUM_WB*ADDR_W-1:0] wb_addr,
   input  logic [NUM_WB*DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0]        data
);

   // Scan from the highest port down so lower ports overwrite and take priority.
   always_comb begin
      data = rf_data;
      for (int i = NUM_WB - 1; i >= 0; i--) begin
         if (wb_we[i] && (wb_addr[i*ADDR_W +: ADDR_W] == src_addr))
            data = wb_data[i*DATA_W +: DATA_W];
      end
   end

endmodule

// File: rtl/dex_pipe_ctrl.sv
// Decode/execute stage controller: handshake, forwarding, load-use interlock,
// flush, and multi-cycle sequencing for VPU launch and timed WAIT.
//
// state      | meaning
// IDLE       | accepting instructions, output register drains normally
// VPU_LAUNCH | one-cycle vpu_start pulse
// VPU_WAIT   | waiting for vpu_rdy; kill suppresses the result
// TIMED_WAIT | down-counting a WAIT; result issues when the count hits 1
module dex_pipe_ctrl
   import dex_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 5,
   parameter int NUM_WB    = 2,
   parameter int WAIT_W    = 11,
   parameter int PAYLOAD_W = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               in_kind,
   input  logic [ADDR_W-1:0]        in_src0_addr,
   input  logic [ADDR_W-1:0]        in_src1_addr,
   input  logic [ADDR_W-1:0]        in_dst_addr,
   input  logic [DATA_W-1:0]        in_src0_data,
   input  logic [DATA_W-1:0]        in_src1_data,
   input  logic                     in_mem_re,
   input  logic [WAIT_W-1:0]        in_wait_cycles,
   input  logic [2:0]               in_flags,
   input  logic [2:0]               in_flags_we,
   input  logic [PAYLOAD_W-1:0]     in_payload,
   input  logic [NUM_WB-1:0]        wb_we,
   input  logic [NUM_WB*ADDR_W-1:0] wb_addr,
   input  logic [NUM_WB*DATA_W-1:0] wb_data,
   input  logic                     flush,
   input  logic                     vpu_rdy,
   output logic                     vpu_start,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_src0,
   output logic [DATA_W-1:0]        out_src1,
   output logic [ADDR_W-1:0]        out_dst_addr,
   output logic                     out_mem_re,
   output logic [PAYLOAD_W-1:0]     out_payload,
   output logic [2:0]               flags,
   output logic                     stall
);

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   cnt_q, cnt_d;
   logic                kill_q, kill_d;
   logic                out_valid_d;
   logic                hazard;
   logic                accept;
   kind_e               kind;
   logic [DATA_W-1:0]   fwd0, fwd1;

   dex_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WB(NUM_WB)) u_fwd0 (
      .src_addr (in_src0_addr),
      .rf_data  (in_src0_data),
      .wb_we    (wb_we),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .data     (fwd0)
   );

   dex_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WB(NUM_WB)) u_fwd1 (
      .src_addr (in_src1_addr),
      .rf_data  (in_src1_data),
      .wb_we    (wb_we),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .data     (fwd1)
   );

   assign kind      = decode_kind(in_kind);
   assign hazard    = out_valid & out_mem_re &
                      ((out_dst_addr == in_src0_addr) | (out_dst_addr == in_src1_addr));
   assign in_ready  = (state_q == IDLE) & ~hazard & ~flush & (~out_valid | out_ready);
   assign accept    = in_valid & in_ready;
   assign stall     = in_valid & ~in_ready;
   assign vpu_start = (state_q == VPU_LAUNCH);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      kill_d      = kill_q;
      out_valid_d = out_valid & ~out_ready;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (kind)
                  VPU: begin
                     state_d     = VPU_LAUNCH;
                     out_valid_d = 1'b0;
                  end
                  WAIT: begin
                     if (in_wait_cycles != '0) begin
                        cnt_d       = in_wait_cycles;
                        state_d     = TIMED_WAIT;
                        out_valid_d = 1'b0;
                     end else begin
                        out_valid_d = 1'b1;
                     end
                  end
                  default: out_valid_d = 1'b1;
               endcase
            end
         end
         VPU_LAUNCH: begin
            state_d = VPU_WAIT;
            if (flush) kill_d = 1'b1;
         end
         VPU_WAIT: begin
            // A launched VPU op cannot be cancelled, so a kill only drops the result.
            if (vpu_rdy) begin
               state_d     = IDLE;
               kill_d      = 1'b0;
               out_valid_d = ~kill_q & ~flush;
            end else if (flush) begin
               kill_d = 1'b1;
            end
         end
         TIMED_WAIT: begin
            if (flush) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - WAIT_W'(1);
               if (cnt_q == WAIT_W'(1)) begin
                  state_d     = IDLE;
                  out_valid_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush) out_valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         kill_q       <= 1'b0;
         out_valid    <= 1'b0;
         out_src0     <= '0;
         out_src1     <= '0;
         out_dst_addr <= '0;
         out_mem_re   <= 1'b0;
         out_payload  <= '0;
         flags        <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         kill_q    <= kill_d;
         out_valid <= out_valid_d;
         if (accept) begin
            out_src0     <= fwd0;
            out_src1     <= fwd1;
            out_dst_addr <= in_dst_addr;
            out_mem_re   <= in_mem_re;
            out_payload  <= in_payload;
            flags        <= (flags & ~in_flags_we) | (in_flags & in_flags_we);
         end
      end
   end

endmodule

// File: tb/tb_dex_pipe_ctrl.sv
// Self-checking bench for dex_pipe_ctrl: vector table, hand-written corner
// sequences, and a randomized stream checked against a transaction-level model.
module tb_dex_pipe_ctrl;
   import dex_pkg::*;

   localparam int DATA_W = 16, ADDR_W = 5, NUM_WB = 2, WAIT_W = 11, PAYLOAD_W = 64;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     in_valid, in_ready;
   logic [1:0]               in_kind;
   logic [ADDR_W-1:0]        in_src0_addr, in_src1_addr, in_dst_addr;
   logic [DATA_W-1:0]        in_src0_data, in_src1_data;
   logic                     in_mem_re;
   logic [WAIT_W-1:0]        in_wait_cycles;
   logic [2:0]               in_flags, in_flags_we;
   logic [PAYLOAD_W-1:0]     in_payload;
   logic [NUM_WB-1:0]        wb_we;
   logic [NUM_WB*ADDR_W-1:0] wb_addr;
   logic [NUM_WB*DATA_W-1:0] wb_data;
   logic                     flush, vpu_rdy, vpu_start;
   logic                     out_valid, out_ready;
   logic [DATA_W-1:0]        out_src0, out_src1;
   logic [ADDR_W-1:0]        out_dst_addr;
   logic                     out_mem_re;
   logic [PAYLOAD_W-1:0]     out_payload;
   logic [2:0]               flags;
   logic                     stall;

   dex_pipe_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WB(NUM_WB),
      .WAIT_W(WAIT_W), .PAYLOAD_W(PAYLOAD_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
      .in_src0_addr(in_src0_addr), .in_src1_addr(in_src1_addr), .in_dst_addr(in_dst_addr),
      .in_src0_data(in_src0_data), .in_src1_data(in_src1_data),
      .in_mem_re(in_mem_re), .in_wait_cycles(in_wait_cycles),
      .in_flags(in_flags), .in_flags_we(in_flags_we), .in_payload(in_payload),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .flush(flush), .vpu_rdy(vpu_rdy), .vpu_start(vpu_start),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_src0(out_src0), .out_src1(out_src1), .out_dst_addr(out_dst_addr),
      .out_mem_re(out_mem_re), .out_payload(out_payload),
      .flags(flags), .stall(stall)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0; in_kind = 2'd0; in_mem_re = 1'b0; in_wait_cycles = '0;
      in_src0_addr = '0; in_src1_addr = '0; in_dst_addr = '0;
      in_src0_data = '0; in_src1_data = '0;
      in_flags = '0; in_flags_we = '0; in_payload = '0;
      wb_we = '0; wb_addr = '0; wb_data = '0;
      flush = 1'b0; vpu_rdy = 1'b0; out_ready = 1'b1;
   endtask

   task automatic issue(input logic [1:0] k, input logic [WAIT_W-1:0] w,
                        input logic [ADDR_W-1:0] s0, input logic [ADDR_W-1:0] s1,
                        input logic [ADDR_W-1:0] dst, input logic [DATA_W-1:0] d0,
                        input logic [DATA_W-1:0] d1, input logic mr, input logic [63:0] pl);
      in_valid = 1'b1; in_kind = k; in_wait_cycles = w;
      in_src0_addr = s0; in_src1_addr = s1; in_dst_addr = dst;
      in_src0_data = d0; in_src1_data = d1; in_mem_re = mr; in_payload = pl;
      in_flags_we = '0; wb_we = '0;
   endtask

   // Reference forwarding: first writeback port (from 0 upward) that hits wins.
   function automatic logic [DATA_W-1:0] ref_fwd(input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] rf);
      for (int i = 0; i < NUM_WB; i++)
         if (wb_we[i] && wb_addr[i*ADDR_W +: ADDR_W] == a) return wb_data[i*DATA_W +: DATA_W];
      return rf;
   endfunction

   typedef struct {
      logic [ADDR_W-1:0]        s0, s1;
      logic [DATA_W-1:0]        d0, d1;
      logic [NUM_WB-1:0]        we;
      logic [NUM_WB*ADDR_W-1:0] wa;
      logic [NUM_WB*DATA_W-1:0] wd;
      logic [2:0]               fl, fwe;
      logic [DATA_W-1:0]        e0, e1;
      logic [2:0]               ef;
   } vec_t;

   vec_t vt[5];

   logic                 m_valid, m_mem_re, hz, er;
   logic [DATA_W-1:0]    m_s0, m_s1;
   logic [ADDR_W-1:0]    m_dst;
   logic [PAYLOAD_W-1:0] m_pl;
   logic [2:0]           m_flags;
   int                   pulses;

   initial begin
      vt[0] = '{5'd3, 5'd4, 16'hAAAA, 16'hBBBB, 2'b00, {5'd0, 5'd0}, {16'h0, 16'h0},
                3'b111, 3'b100, 16'hAAAA, 16'hBBBB, 3'b100};
      vt[1] = '{5'd3, 5'd7, 16'h3333, 16'h0707, 2'b11, {5'd3, 5'd3}, {16'h2222, 16'h1111},
                3'b000, 3'b000, 16'h1111, 16'h0707, 3'b100};
      vt[2] = '{5'd5, 5'd5, 16'h1234, 16'h4321, 2'b10, {5'd5, 5'd5}, {16'h5555, 16'h9999},
                3'b011, 3'b011, 16'h5555, 16'h5555, 3'b111};
      vt[3] = '{5'd0, 5'd2, 16'h0000, 16'h0202, 2'b01, {5'd1, 5'd0}, {16'hDEAD, 16'h0F0F},
                3'b000, 3'b010, 16'h0F0F, 16'h0202, 3'b101};
      vt[4] = '{5'd9, 5'd6, 16'h0000, 16'h0000, 2'b11, {5'd9, 5'd6}, {16'h9999, 16'h6666},
                3'b010, 3'b001, 16'h9999, 16'h6666, 3'b100};

      idle();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_vpu_start", 64'(vpu_start), 64'd0);
      chk("rst_flags", 64'(flags), 64'd0);
      chk("rst_out_src0", 64'(out_src0), 64'd0);
      chk("rst_out_payload", out_payload, 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // Back-to-back NORMAL stream from the vector table.
      for (int i = 0; i < 5; i++) begin
         issue(2'd0, '0, vt[i].s0, vt[i].s1, 5'(i + 10), vt[i].d0, vt[i].d1, 1'b0,
               64'hC0DE_0000_0000_0000 | 64'(i));
         wb_we = vt[i].we; wb_addr = vt[i].wa; wb_data = vt[i].wd;
         in_flags = vt[i].fl; in_flags_we = vt[i].fwe;
         #1;
         chk("tbl_in_ready", 64'(in_ready), 64'd1);
         tick();
         chk("tbl_out_valid", 64'(out_valid), 64'd1);
         chk("tbl_src0", 64'(out_src0), 64'(vt[i].e0));
         chk("tbl_src1", 64'(out_src1), 64'(vt[i].e1));
         chk("tbl_flags", 64'(flags), 64'(vt[i].ef));
         chk("tbl_dst", 64'(out_dst_addr), 64'(i + 10));
         chk("tbl_payload", out_payload, 64'hC0DE_0000_0000_0000 | 64'(i));
      end
      idle();
      tick();
      chk("stream_end_valid", 64'(out_valid), 64'd0);

      // Load-use interlock: exactly one bubble, then forwarding from port 1.
      issue(2'd0, '0, 5'd1, 5'd2, 5'd5, 16'h0101, 16'h0202, 1'b1, 64'h10AD);
      tick();
      chk("load_valid", 64'(out_valid), 64'd1);
      chk("load_mem_re", 64'(out_mem_re), 64'd1);
      issue(2'd0, '0, 5'd5, 5'd6, 5'd7, 16'h0505, 16'h0606, 1'b0, 64'hADD);
      #1;
      chk("lu_stall_first", 64'(stall), 64'd1);
      tick();
      chk("lu_bubble", 64'(out_valid), 64'd0);
      wb_we = 2'b10; wb_addr = {5'd5, 5'd4}; wb_data = {16'hBEEF, 16'h4444};
      #1;
      chk("lu_stall_second", 64'(stall), 64'd0);
      tick();
      chk("lu_issue_valid", 64'(out_valid), 64'd1);
      chk("lu_fwd_src0", 64'(out_src0), 64'h0000_0000_0000_BEEF);
      chk("lu_dst", 64'(out_dst_addr), 64'd7);
      idle();
      tick();

      // WAIT 5: result appears five edges after the accept edge.
      issue(2'd2, 11'd5, 5'd1, 5'd2, 5'd3, 16'h5A5A, 16'h0000, 1'b0, 64'h5);
      tick();
      idle();
      for (int i = 0; i < 5; i++) begin
         chk("wait5_valid_low", 64'(out_valid), 64'd0);
         chk("wait5_ready_low", 64'(in_ready), 64'd0);
         tick();
      end
      chk("wait5_valid", 64'(out_valid), 64'd1);
      chk("wait5_src0", 64'(out_src0), 64'h5A5A);
      tick();

      issue(2'd2, 11'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 16'h0000, 1'b0, 64'h0);
      tick();
      chk("wait0_valid", 64'(out_valid), 64'd1);
      idle();
      tick();

      // VPU launch with vpu_rdy seven cycles after accept.
      issue(2'd1, '0, 5'd1, 5'd2, 5'd3, 16'h0000, 16'h0000, 1'b0, 64'hA5);
      tick();
      idle();
      pulses = int'(vpu_start);
      chk("vpu_start_after_accept", 64'(vpu_start), 64'd1);
      chk("vpu_launch_valid", 64'(out_valid), 64'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         pulses += int'(vpu_start);
         chk("vpu_wait_valid", 64'(out_valid), 64'd0);
         chk("vpu_wait_ready", 64'(in_ready), 64'd0);
      end
      vpu_rdy = 1'b1;
      tick();
      pulses += int'(vpu_start);
      vpu_rdy = 1'b0;
      chk("vpu_done_valid", 64'(out_valid), 64'd1);
      chk("vpu_done_payload", out_payload, 64'hA5);
      chk("vpu_start_pulses", 64'(pulses), 64'd1);
      tick();

      // VPU killed by flush: waits for vpu_rdy, then returns to IDLE silently.
      issue(2'd1, '0, 5'd1, 5'd2, 5'd3, 16'h0000, 16'h0000, 1'b0, 64'hB6);
      tick();
      idle();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("vpukill_ready", 64'(in_ready), 64'd0);
         chk("vpukill_valid", 64'(out_valid), 64'd0);
         tick();
      end
      vpu_rdy = 1'b1;
      tick();
      vpu_rdy = 1'b0;
      #1;
      chk("vpukill_done_valid", 64'(out_valid), 64'd0);
      chk("vpukill_idle", 64'(in_ready), 64'd1);

      issue(2'd1, '0, 5'd1, 5'd2, 5'd3, 16'h0000, 16'h0000, 1'b0, 64'hC7);
      tick();
      idle();
      tick();
      flush = 1'b1; vpu_rdy = 1'b1;
      tick();
      flush = 1'b0; vpu_rdy = 1'b0;
      #1;
      chk("vpusim_valid", 64'(out_valid), 64'd0);
      chk("vpusim_idle", 64'(in_ready), 64'd1);

      // Downstream backpressure holds the output register.
      issue(2'd0, '0, 5'd1, 5'd2, 5'd4, 16'h0A0A, 16'h0000, 1'b0, 64'h1234_5678_9ABC_DEF0);
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b0;
      issue(2'd0, '0, 5'd1, 5'd2, 5'd8, 16'h0B0B, 16'h0000, 1'b0, 64'h0FED_CBA9);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         tick();
         chk("bp_hold_valid", 64'(out_valid), 64'd1);
         chk("bp_hold_payload", out_payload, 64'h1234_5678_9ABC_DEF0);
         chk("bp_hold_src0", 64'(out_src0), 64'h0A0A);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 64'(in_ready), 64'd1);
      tick();
      chk("bp_next_payload", out_payload, 64'h0FED_CBA9);
      chk("bp_next_src0", 64'(out_src0), 64'h0B0B);
      idle();
      tick();

      // Flush during TIMED_WAIT returns to IDLE at once.
      issue(2'd2, 11'd10, 5'd1, 5'd2, 5'd3, 16'h0000, 16'h0000, 1'b0, 64'h0);
      tick();
      idle();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("twflush_idle", 64'(in_ready), 64'd1);
      chk("twflush_valid", 64'(out_valid), 64'd0);

      // Reset in the middle of a long WAIT.
      issue(2'd2, 11'd20, 5'd1, 5'd2, 5'd3, 16'h7777, 16'h8888, 1'b1, 64'hFFFF);
      in_flags = 3'b111; in_flags_we = 3'b111;
      tick();
      idle();
      tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("rstw_valid", 64'(out_valid), 64'd0);
      chk("rstw_flags", 64'(flags), 64'd0);
      chk("rstw_src0", 64'(out_src0), 64'd0);
      chk("rstw_src1", 64'(out_src1), 64'd0);
      chk("rstw_dst", 64'(out_dst_addr), 64'd0);
      chk("rstw_mem_re", 64'(out_mem_re), 64'd0);
      chk("rstw_payload", out_payload, 64'd0);
      chk("rstw_vpu_start", 64'(vpu_start), 64'd0);
      chk("rstw_idle", 64'(in_ready), 64'd1);

      // Randomized NORMAL-class traffic against the transaction model.
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m_valid = 1'b0; m_mem_re = 1'b0; m_s0 = '0; m_s1 = '0; m_dst = '0; m_pl = '0;
      m_flags = '0;
      for (int c = 0; c < 400; c++) begin
         in_valid = ($urandom_range(3) != 0);
         case ($urandom_range(2))
            0:       in_kind = 2'd0;
            1:       in_kind = 2'd3;
            default: in_kind = 2'd2;
         endcase
         in_wait_cycles = '0;
         in_src0_addr = 5'($urandom_range(7));
         in_src1_addr = 5'($urandom_range(7));
         in_dst_addr  = 5'($urandom_range(7));
         in_src0_data = 16'($urandom);
         in_src1_data = 16'($urandom);
         in_mem_re    = ($urandom_range(2) == 0);
         in_flags     = 3'($urandom);
         in_flags_we  = 3'($urandom);
         in_payload   = {$urandom, $urandom};
         wb_we        = 2'($urandom);
         wb_addr      = 10'($urandom) & 10'b00111_00111;
         wb_data      = $urandom;
         flush        = ($urandom_range(15) == 0);
         out_ready    = ($urandom_range(3) != 0);
         #1;
         hz = m_valid && m_mem_re && (m_dst == in_src0_addr || m_dst == in_src1_addr);
         er = !hz && !flush && (!m_valid || out_ready);
         chk("rnd_in_ready", 64'(in_ready), 64'(er));
         chk("rnd_stall", 64'(stall), 64'(in_valid && !er));
         if (flush) begin
            m_valid = 1'b0;
         end else if (in_valid && er) begin
            m_valid  = 1'b1;
            m_s0     = ref_fwd(in_src0_addr, in_src0_data);
            m_s1     = ref_fwd(in_src1_addr, in_src1_data);
            m_dst    = in_dst_addr;
            m_mem_re = in_mem_re;
            m_pl     = in_payload;
            for (int b = 0; b < 3; b++)
               if (in_flags_we[b]) m_flags[b] = in_flags[b];
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
         tick();
         chk("rnd_out_valid", 64'(out_valid), 64'(m_valid));
         chk("rnd_src0", 64'(out_src0), 64'(m_s0));
         chk("rnd_src1", 64'(out_src1), 64'(m_s1));
         chk("rnd_dst", 64'(out_dst_addr), 64'(m_dst));
         chk("rnd_mem_re", 64'(out_mem_re), 64'(m_mem_re));
         chk("rnd_payload", out_payload, m_pl);
         chk("rnd_flags", 64'(flags), 64'(m_flags));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: actual running required finished");
      $fatal(1);
   end

endmodule

// File: doc/dex_pipe_ctrl.md
# dex_pipe_ctrl

Parametrised decode/execute pipeline stage controller for the CPU, the successor to the fixed 16-bit DEX register bank. It sits between decode/register-read and the memory/writeback stage. It adds a valid/ready handshake, writeback operand forwarding across `NUM_WB` ports, load-use interlock, branch flush, and a multi-cycle FSM for VPU launch and timed WAIT instructions. Condition flags are committed only when an instruction is actually accepted.

## Interface
- `DATA_W`, 16: operand/data width
- `ADDR_W`, 5: register address width
- `NUM_WB`, 2: writeback ports checked for forwarding
- `WAIT_W`, 11: WAIT cycle-count width
- `PAYLOAD_W`, 64: opaque control/result bundle passed through unchanged
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid` / `in_ready`  in/out  1  upstream handshake
- `in_kind`  in  2  0 NORMAL, 1 VPU, 2 WAIT (3 treated as NORMAL)
- `in_src0_addr`, `in_src1_addr`, `in_dst_addr`  in  ADDR_W  source and destination registers
- `in_src0_data`, `in_src1_data`  in  DATA_W  register-file read data
- `in_mem_re`  in  1  instruction is a load
- `in_wait_cycles`  in  WAIT_W  WAIT length
- `in_flags`, `in_flags_we`  in  3 each  {Z,N,V} from the ALU and per-flag enables
- `in_payload`  in  PAYLOAD_W
- `wb_we`  in  NUM_WB; `wb_addr`  in  NUM_WB*ADDR_W; `wb_data`  in  NUM_WB*DATA_W (all flattened, port 0 in LSBs)
- `flush`  in  1  branch/jump taken; kill the younger instruction
- `vpu_rdy`  in  1  VPU done/idle
- `vpu_start`  out  1  one-cycle VPU launch pulse
- `out_valid` / `out_ready`  out/in  1  downstream handshake
- `out_src0`, `out_src1`  out  DATA_W; `out_dst_addr`  out  ADDR_W; `out_mem_re`  out  1; `out_payload`  out  PAYLOAD_W
- `flags`  out  3  committed {Z,N,V}
- `stall`  out  1  `in_valid & ~in_ready`

## Operation
- Accept means `in_valid & in_ready`.
- `in_ready = (state==IDLE) & ~hazard & ~flush & (~out_valid | out_ready)`.
- hazard = `out_valid & out_mem_re & (out_dst_addr==in_src0_addr | out_dst_addr==in_src1_addr)`. It clears once the load drains, which inserts exactly one bubble.
- Forwarding: each source takes `wb_data[i]` for the lowest i with `wb_we[i] & wb_addr[i]==src_addr`. Otherwise it takes the register-file data. There is no R0 special case.
- On accept, the output register loads the forwarded sources, dst, mem_re and payload. For each set bit of `in_flags_we`, the matching flag bit updates.
- FSM states:
  - IDLE:
    - NORMAL, or WAIT with count 0: `out_valid` is set next cycle.
    - VPU: go to VPU_LAUNCH and keep `out_valid` low.
    - WAIT with count N>0: load the counter with N, go to TIMED_WAIT, keep `out_valid` low.
  - VPU_LAUNCH: `vpu_start=1` for this cycle only; go to VPU_WAIT. `vpu_rdy` is ignored in this state.
  - VPU_WAIT: on `vpu_rdy`, set `out_valid` (unless killed) and go to IDLE.
  - TIMED_WAIT: decrement the counter each cycle. When it reaches 1, set `out_valid` next cycle and go to IDLE.
- `flush`:
  - Always clears `out_valid`, and the upstream instruction presented that cycle is not accepted.
  - TIMED_WAIT goes to IDLE immediately.
  - VPU_LAUNCH/VPU_WAIT set a kill bit. The FSM still waits for `vpu_rdy` (a launched VPU cannot be cancelled), then returns to IDLE without asserting `out_valid`.
  - Flags already committed are not rolled back.
- `out_valid & ~out_ready` holds all outputs stable.

## Timing
- Reset values: `out_valid=0`, `vpu_start=0`, `flags=0`, all data/address/payload outputs 0, state IDLE, counter 0, kill 0.
- Latency:
  - NORMAL: accept at edge k, `out_valid` from k.
  - WAIT N: `out_valid` N cycles after the NORMAL case.
  - VPU: `vpu_start` is high in the cycle after accept; `out_valid` rises the edge after `vpu_rdy` is sampled in VPU_WAIT.
- Sustained throughput is 1/cycle for NORMAL with `out_ready=1`.
- Simultaneous flush and `vpu_rdy` in VPU_WAIT: go to IDLE, no output.
- Reset mid-VPU: return to IDLE. The VPU handshake is the top level's responsibility.
- The counter never wraps: a max count of 2^WAIT_W-1 is honoured exactly.

## Structure
- Package `dex_pkg`: `kind_e` (NORMAL/VPU/WAIT), `state_e` (IDLE/VPU_LAUNCH/VPU_WAIT/TIMED_WAIT), flag bit indices Z=2, N=1, V=0.
- Sub-module `dex_fwd_mux`, instantiated twice: a priority bypass mux over `NUM_WB` ports.

## Test plan
- NORMAL stream of 4 back-to-back, `out_ready=1` -> 4 consecutive `out_valid` cycles; `flags` follow `in_flags_we`. E.g. we=3'b100 with Z=1 changes only Z.
- Load to R5 followed by an ADD reading R5 -> `stall=1` for exactly 1 cycle; the ADD issues next with `wb_data` forwarded when `wb_we[1]`/`wb_addr[1]=5`.
- Both wb ports writing R3 (port0=16'h1111, port1=16'h2222) while src0=R3 -> `out_src0=16'h1111`.
- WAIT 5 -> `out_valid` 5 cycles later than NORMAL; `in_ready` is low throughout. WAIT 0 behaves as NORMAL.
- VPU op, `vpu_rdy` after 7 cycles -> single `vpu_start` pulse, `out_valid` on the following edge. A repeat run with `flush` during VPU_WAIT -> no `out_valid`, and IDLE only after `vpu_rdy`.
- `out_ready=0` for 3 cycles with `out_valid` high -> outputs are stable and `in_ready=0`. Asserting reset mid-TIMED_WAIT -> all reset values next cycle.
